// File: rtl/array_stream_packer.sv
// array_stream_packer: gathers DEPTH scalar words from a sync/notify input
// port into a register array and offers the whole array as one word on a
// sync/notify output port. MODE 0 fills the array then sends it. MODE 1 is a
// sliding window where element 0 is the newest word.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_READ | accepting scalar words (m_in_notify=1)
// ST_WRITE| array frozen and offered to the consumer (m_out_notify=1)
module array_stream_packer #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 5,
    parameter int MODE   = 0,
    parameter int FCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       m_in,
    input  logic                   m_in_sync,
    output logic                   m_in_notify,
    output logic [DEPTH*WIDTH-1:0] m_out,
    input  logic                   m_out_sync,
    output logic                   m_out_notify,
    output logic [FCNT_W-1:0]      frame_cnt
);

    // A DEPTH of 1 still needs a one-bit index so the compare logic stays legal.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    generate
        if (WIDTH < 1 || DEPTH < 1 || (MODE != 0 && MODE != 1)) begin : g_bad_param
            $error("array_stream_packer: illegal WIDTH/DEPTH/MODE parameters");
        end
    endgenerate

    typedef enum logic {
        ST_READ  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DEPTH*WIDTH-1:0] arr_q, arr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;

    // Notify flags decode straight from the state register, so no sync input
    // reaches them combinationally.
    assign m_in_notify  = (state_q == ST_READ);
    assign m_out_notify = (state_q == ST_WRITE);
    assign m_out        = arr_q;
    assign frame_cnt    = fcnt_q;

    // State, array, index, fill count and frame counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_READ;
            arr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic: capture words in READ, hand the array off in WRITE.
    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_READ: begin
                if (m_in_sync) begin
                    if (MODE == 0) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                arr_d[k*WIDTH +: WIDTH] = m_in;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = ST_WRITE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        for (int k = DEPTH - 1; k >= 1; k--) begin
                            arr_d[k*WIDTH +: WIDTH] = arr_q[(k-1)*WIDTH +: WIDTH];
                        end
                        arr_d[WIDTH-1:0] = m_in;
                        // Once saturated, every new word completes a window.
                        cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_FULL) begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (m_out_sync) begin
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_READ;
        endcase
    end

endmodule

// File: tb/tb_array_stream_packer.sv
// Directed bench for array_stream_packer: four instances cover block mode
// (DEPTH 5), sliding window (DEPTH 3), DEPTH 1 and frame-counter wrap.
module tb_array_stream_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: WIDTH 32, DEPTH 5, MODE 0
    logic [31:0]  a_in = '0;
    logic         a_in_sync = 1'b0, a_in_notify, a_out_sync = 1'b0, a_out_notify;
    logic [159:0] a_out;
    logic [15:0]  a_fcnt;
    // Instance B: WIDTH 8, DEPTH 3, MODE 1
    logic [7:0]   b_in = '0;
    logic         b_in_sync = 1'b0, b_in_notify, b_out_sync = 1'b0, b_out_notify;
    logic [23:0]  b_out;
    logic [15:0]  b_fcnt;
    // Instance C: WIDTH 8, DEPTH 1, MODE 0
    logic [7:0]   c_in = '0;
    logic         c_in_sync = 1'b0, c_in_notify, c_out_sync = 1'b0, c_out_notify;
    logic [7:0]   c_out;
    logic [15:0]  c_fcnt;
    // Instance D: WIDTH 8, DEPTH 2, MODE 0, FCNT_W 2
    logic [7:0]   d_in = '0;
    logic         d_in_sync = 1'b0, d_in_notify, d_out_sync = 1'b0, d_out_notify;
    logic [15:0]  d_out;
    logic [1:0]   d_fcnt;

    array_stream_packer #(.WIDTH(32), .DEPTH(5), .MODE(0), .FCNT_W(16)) u_a (
        .clk(clk), .rst(rst), .m_in(a_in), .m_in_sync(a_in_sync), .m_in_notify(a_in_notify),
        .m_out(a_out), .m_out_sync(a_out_sync), .m_out_notify(a_out_notify), .frame_cnt(a_fcnt));
    array_stream_packer #(.WIDTH(8), .DEPTH(3), .MODE(1), .FCNT_W(16)) u_b (
        .clk(clk), .rst(rst), .m_in(b_in), .m_in_sync(b_in_sync), .m_in_notify(b_in_notify),
        .m_out(b_out), .m_out_sync(b_out_sync), .m_out_notify(b_out_notify), .frame_cnt(b_fcnt));
    array_stream_packer #(.WIDTH(8), .DEPTH(1), .MODE(0), .FCNT_W(16)) u_c (
        .clk(clk), .rst(rst), .m_in(c_in), .m_in_sync(c_in_sync), .m_in_notify(c_in_notify),
        .m_out(c_out), .m_out_sync(c_out_sync), .m_out_notify(c_out_notify), .frame_cnt(c_fcnt));
    array_stream_packer #(.WIDTH(8), .DEPTH(2), .MODE(0), .FCNT_W(2)) u_d (
        .clk(clk), .rst(rst), .m_in(d_in), .m_in_sync(d_in_sync), .m_in_notify(d_in_notify),
        .m_out(d_out), .m_out_sync(d_out_sync), .m_out_notify(d_out_notify), .frame_cnt(d_fcnt));

    // Drive five words base + step*i into instance A, one per cycle.
    // Called and returns at a falling edge.
    task automatic a_feed(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 5; i++) begin
            a_in      = base + step * i;
            a_in_sync = 1'b1;
            @(negedge clk);
        end
        a_in_sync = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (a_in_notify !== 1'b1 || a_out_notify !== 1'b0) begin
            errors++;
            $display("FAIL reset_notify: got in=%b out=%b want in=1 out=0", a_in_notify, a_out_notify);
        end
        checks++;
        if (a_out !== '0 || a_fcnt !== '0) begin
            errors++;
            $display("FAIL reset_data: got out=%h fcnt=%0d want 0 0", a_out, a_fcnt);
        end
    endtask

    task automatic test_mode0();
        logic [159:0] exp;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 5; k++) begin
                exp[k*32 +: 32] = (f == 0) ? 32'(10 * (k + 1)) : 32'(k + 1);
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (a_in_notify !== 1'b1 || a_out_notify !== 1'b0) begin
                    errors++;
                    $display("FAIL mode0_read f%0d i%0d: got in=%b out=%b want 1 0", f, i, a_in_notify, a_out_notify);
                end
                a_in      = (f == 0) ? 32'(10 * (i + 1)) : 32'(i + 1);
                a_in_sync = 1'b1;
                @(negedge clk);
            end
            a_in_sync = 1'b0;
            checks++;
            if (a_out_notify !== 1'b1 || a_in_notify !== 1'b0 || a_out !== exp) begin
                errors++;
                $display("FAIL mode0_write f%0d: got on=%b in=%b out=%h want 1 0 %h", f, a_out_notify, a_in_notify, a_out, exp);
            end
            a_out_sync = 1'b1;
            @(negedge clk);
            a_out_sync = 1'b0;
            checks++;
            if (a_out_notify !== 1'b0 || a_in_notify !== 1'b1 || a_fcnt !== 16'(f + 1)) begin
                errors++;
                $display("FAIL mode0_done f%0d: got on=%b in=%b fcnt=%0d want 0 1 %0d", f, a_out_notify, a_in_notify, a_fcnt, f + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [159:0] exp;
        for (int k = 0; k < 5; k++) exp[k*32 +: 32] = 32'(100 + k);
        a_feed(32'd100, 32'd1);
        a_in      = 32'd555;
        a_in_sync = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (a_in_notify !== 1'b0 || a_out_notify !== 1'b1 || a_out !== exp || a_fcnt !== 16'd2) begin
                errors++;
                $display("FAIL bp_hold c%0d: got in=%b on=%b out=%h fcnt=%0d want 0 1 %h 2", c, a_in_notify, a_out_notify, a_out, a_fcnt, exp);
            end
        end
        a_in_sync  = 1'b0;
        a_out_sync = 1'b1;
        @(negedge clk);
        a_out_sync = 1'b0;
        checks++;
        if (a_in_notify !== 1'b1 || a_out_notify !== 1'b0 || a_fcnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_release: got in=%b on=%b fcnt=%0d want 1 0 3", a_in_notify, a_out_notify, a_fcnt);
        end
        checks++;
        if (a_out !== exp) begin
            errors++;
            $display("FAIL bp_not_cleared: got %h want %h", a_out, exp);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [159:0] exp;
        for (int k = 0; k < 5; k++) exp[k*32 +: 32] = 32'(11 * (k + 1));
        a_in = 32'd77; a_in_sync = 1'b1;
        @(negedge clk);
        a_in = 32'd88;
        @(negedge clk);
        a_in_sync = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_in_notify !== 1'b1 || a_out_notify !== 1'b0 || a_out !== '0 || a_fcnt !== '0) begin
            errors++;
            $display("FAIL async_reset: got in=%b on=%b out=%h fcnt=%0d want 1 0 0 0", a_in_notify, a_out_notify, a_out, a_fcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        a_feed(32'd11, 32'd11);
        checks++;
        if (a_out_notify !== 1'b1 || a_out !== exp) begin
            errors++;
            $display("FAIL reset_new_frame: got on=%b out=%h want 1 %h", a_out_notify, a_out, exp);
        end
        a_out_sync = 1'b1;
        @(negedge clk);
        a_out_sync = 1'b0;
        checks++;
        if (a_fcnt !== 16'd1 || a_in_notify !== 1'b1) begin
            errors++;
            $display("FAIL reset_fcnt: got fcnt=%0d in=%b want 1 1", a_fcnt, a_in_notify);
        end
    endtask

    task automatic test_sliding();
        // Window contents after each WRITE: e0 newest, packed {e2,e1,e0}.
        logic [23:0] exp1, exp2;
        exp1 = {8'd1, 8'd2, 8'd3};
        exp2 = {8'd2, 8'd3, 8'd4};
        b_out_sync = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            b_in = 8'(i); b_in_sync = 1'b1;
            @(negedge clk);
            checks++;
            if (b_in_notify !== 1'b1 || b_out_notify !== 1'b0) begin
                errors++;
                $display("FAIL slide_fill i%0d: got in=%b on=%b want 1 0", i, b_in_notify, b_out_notify);
            end
        end
        b_in = 8'd3;
        @(negedge clk);
        checks++;
        if (b_out_notify !== 1'b1 || b_out !== exp1) begin
            errors++;
            $display("FAIL slide_first: got on=%b out=%h want 1 %h", b_out_notify, b_out, exp1);
        end
        b_in = 8'd4;
        @(negedge clk);
        checks++;
        if (b_in_notify !== 1'b1 || b_fcnt !== 16'd1) begin
            errors++;
            $display("FAIL slide_back: got in=%b fcnt=%0d want 1 1", b_in_notify, b_fcnt);
        end
        @(negedge clk);
        b_in_sync = 1'b0;
        checks++;
        if (b_out_notify !== 1'b1 || b_out !== exp2) begin
            errors++;
            $display("FAIL slide_second: got on=%b out=%h want 1 %h", b_out_notify, b_out, exp2);
        end
        @(negedge clk);
        b_out_sync = 1'b0;
        checks++;
        if (b_fcnt !== 16'd2 || b_in_notify !== 1'b1) begin
            errors++;
            $display("FAIL slide_fcnt: got fcnt=%0d in=%b want 2 1", b_fcnt, b_in_notify);
        end
    endtask

    task automatic test_depth1();
        c_out_sync = 1'b1;
        c_in = 8'd7; c_in_sync = 1'b1;
        @(negedge clk);
        checks++;
        if (c_out_notify !== 1'b1 || c_in_notify !== 1'b0 || c_out !== 8'd7) begin
            errors++;
            $display("FAIL d1_first: got on=%b in=%b out=%0d want 1 0 7", c_out_notify, c_in_notify, c_out);
        end
        c_in = 8'd8;
        @(negedge clk);
        checks++;
        if (c_in_notify !== 1'b1 || c_fcnt !== 16'd1) begin
            errors++;
            $display("FAIL d1_read: got in=%b fcnt=%0d want 1 1", c_in_notify, c_fcnt);
        end
        @(negedge clk);
        c_in_sync = 1'b0;
        checks++;
        if (c_out_notify !== 1'b1 || c_out !== 8'd8) begin
            errors++;
            $display("FAIL d1_second: got on=%b out=%0d want 1 8", c_out_notify, c_out);
        end
        @(negedge clk);
        c_out_sync = 1'b0;
        checks++;
        if (c_fcnt !== 16'd2 || c_in_notify !== 1'b1) begin
            errors++;
            $display("FAIL d1_fcnt: got fcnt=%0d in=%b want 2 1", c_fcnt, c_in_notify);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        d_in = 8'h5a; d_in_sync = 1'b1; d_out_sync = 1'b1;
        for (int f = 0; f < 5; f++) begin
            repeat (3) @(negedge clk);
            checks++;
            if (d_fcnt !== exp_seq[f] || d_in_notify !== 1'b1) begin
                errors++;
                $display("FAIL wrap f%0d: got fcnt=%0d in=%b want %0d 1", f, d_fcnt, d_in_notify, exp_seq[f]);
            end
        end
        d_in_sync = 1'b0; d_out_sync = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_mode0();
        test_backpressure();
        test_mid_frame_reset();
        test_sliding();
        test_depth1();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_stream_packer.md
# array_stream_packer

Parametrised packer. It collects DEPTH scalar words from a blocking input port into an internal array, then offers the whole array as one word on a blocking output port. It supports a fill-then-send mode and a sliding-window mode. It sits between a scalar producer and an array consumer in generated SCAM-style designs, and uses the same sync/notify port handshake as the rest of the design.

## Interface
- WIDTH, 32, bit width of one array element (≥1)
- DEPTH, 5, number of array elements (≥1)
- MODE, 0, 0 = fill-then-send (block mode), 1 = sliding window
- FCNT_W, 16, width of the frame counter
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- m_in  input  WIDTH  scalar data from producer
- m_in_sync  input  1  producer has valid data on m_in
- m_in_notify  output  1  block ready to consume m_in
- m_out  output  DEPTH*WIDTH  array; element k on bits [k*WIDTH +: WIDTH]
- m_out_sync  input  1  consumer ready to take m_out
- m_out_notify  output  1  m_out valid and offered
- frame_cnt  output  FCNT_W  number of arrays delivered, wraps modulo 2^FCNT_W

## Operation
- Handshake: a transfer occurs on a rising clk edge when notify and sync are both 1 on that port. Sync while notify=0 is ignored.
- Reset values: array all zeros (m_out=0), write index idx=0, fill count cnt=0, state READ, m_in_notify=1, m_out_notify=0, frame_cnt=0.
- FSM states:
  - READ: m_in_notify=1, m_out_notify=0.
  - WRITE: m_in_notify=0, m_out_notify=1.
- READ, MODE 0: on an input transfer, arr[idx] <= m_in.
  - If idx==DEPTH-1: idx<=0, go to WRITE.
  - Otherwise: idx<=idx+1.
- READ, MODE 1: on an input transfer, shift arr[k] <= arr[k-1] for k=DEPTH-1..1, and arr[0] <= m_in (element 0 is newest). cnt saturates at DEPTH.
  - Go to WRITE when cnt (after increment) == DEPTH.
  - After the first fill, every subsequent element triggers WRITE.
- WRITE: the array is frozen and m_out is stable.
  - On an output transfer: frame_cnt<=frame_cnt+1 (wrap), go to READ.
  - The array is not cleared. MODE 0 overwrites it element by element; MODE 1 keeps the history.
- m_out is driven directly from the array registers and is meaningful only while m_out_notify=1.
- DEPTH=1: every input transfer causes a WRITE in both modes. idx/cnt logic must handle the degenerate width.
- Reset mid-frame discards the partial frame. After deassertion the block restarts at idx=0, cnt=0.
- Invalid parameters (WIDTH<1, DEPTH<1, MODE∉{0,1}) are caught by an elaboration-time check and fail.

## Timing
- All outputs are registered; there is no combinational path from sync inputs to notify outputs.
- A handshake in cycle t changes notify in cycle t+1. The array update is visible on m_out at t+1.
- MODE 0, with both partners always syncing: DEPTH input transfers plus 1 output transfer, so one frame every DEPTH+1 cycles.
- MODE 1 steady state: 2 cycles per input element (READ, WRITE).
- Stalls: the block holds indefinitely in READ without m_in_sync, or in WRITE without m_out_sync. State is unchanged while stalled.
- frame_cnt increments in the cycle after the output transfer.

## Test plan
- Reset check: assert rst asynchronously mid-cycle → immediately m_in_notify=1, m_out_notify=0, m_out=0, frame_cnt=0. Repeat mid-frame: after 2 of 5 inputs, reset, then send 5 new words → the frame contains only the new words.
- MODE 0, DEPTH 5, WIDTH 32: inputs 10,20,30,40,50 with m_out_sync=1 → WRITE after the 5th input, m_out elements 0..4 = 10..50, frame_cnt=1, 6 cycles total. Next frame 1..5 → elements 1..5.
- MODE 1, DEPTH 3: inputs 1,2,3,4 with consumer always ready → first output {e0=3,e1=2,e2=1}, second output {4,3,2}, frame_cnt=2.
- Backpressure: hold m_out_sync=0 for 10 cycles in WRITE while m_in_sync=1 → m_in_notify stays 0, m_out stable, no input consumed. Release → one output transfer, then READ.
- DEPTH=1, MODE 0: inputs 7, 8 → outputs 7, then 8, alternating READ/WRITE each cycle.
- Wrap: FCNT_W=2, 5 frames → frame_cnt sequence 1,2,3,0,1.
